// File: rtl/mem2io_responder_if.sv
// Request/response bundle between the LC-3 control path (MAR/MDR side) and the memory responder.
interface mem2io_responder_if;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        R;
  logic [15:0] Data_to_CPU;
  logic        Busy;

  modport master (
    output MEM_EN, WE, ADDR, Data_from_CPU,
    input  R, Data_to_CPU, Busy
  );

  modport slave (
    input  MEM_EN, WE, ADDR, Data_from_CPU,
    output R, Data_to_CPU, Busy
  );
endinterface

// File: rtl/mem2io_responder.sv
// Memory-side responder: word-addressed RAM plus a memory-mapped switch/hex port at 0xFFFF,
// completing each request after WAIT_CYCLES wait states with a one-cycle R pulse.
module mem2io_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       Switches,
  output logic [15:0]       HEX_out,
  mem2io_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] IO_ADDR  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [15:0]           r_addr;
  logic [15:0]           r_wdata;
  logic                  r_ready;
  logic                  r_busy;
  logic [15:0]           r_rdata;
  logic [15:0]           r_hex;
  logic [15:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_we;
  logic [15:0]           w_addr;
  logic [15:0]           w_wdata;
  logic                  w_is_io;
  logic                  w_in_ram;
  logic [ADDR_BITS-1:0]  w_idx;

  assign w_accept = (r_state == S_IDLE) && bus.MEM_EN;

  // With zero wait states the commit happens on the acceptance edge, so the live request is used.
  assign w_commit = ((r_state == S_ACCESS) && (r_cnt == 4'd0)) ||
                    ((WAIT_CYCLES == 0) && w_accept);

  assign w_we     = (r_state == S_IDLE) ? bus.WE            : r_we;
  assign w_addr   = (r_state == S_IDLE) ? bus.ADDR          : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? bus.Data_from_CPU : r_wdata;
  assign w_is_io  = (w_addr == IO_ADDR);
  assign w_in_ram = !w_is_io && ((w_addr >> ADDR_BITS) == 16'd0);
  assign w_idx    = w_addr[ADDR_BITS-1:0];

  // RAM has no reset; an access aborted by Reset never reaches its commit edge.
  always_ff @(posedge Clk) begin
    if (!Reset && w_commit && w_we && w_in_ram) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 16'h0000;
      r_hex   <= 16'h0000;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.MEM_EN) begin
            r_we    <= bus.WE;
            r_addr  <= bus.ADDR;
            r_wdata <= bus.Data_from_CPU;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_commit) begin
        if (w_we) begin
          if (w_is_io) begin
            r_hex <= w_wdata;
          end
        end else if (w_is_io) begin
          r_rdata <= Switches;
        end else if (w_in_ram) begin
          r_rdata <= r_mem[w_idx];
        end else begin
          r_rdata <= 16'h0000;
        end
      end
    end
  end

  assign bus.R           = r_ready;
  assign bus.Busy        = r_busy;
  assign bus.Data_to_CPU = r_rdata;
  assign HEX_out         = r_hex;

endmodule

// File: tb/tb_mem2io_responder.sv
// Scoreboard bench for mem2io_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share clock/reset.
module tb_mem2io_responder;

  typedef struct {
    int          cyc;
    logic [15:0] dout;
    logic [15:0] hex;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] hex0;
  logic [15:0] hex1;
  int          cyc;
  int          total;
  int          bad;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl_mem [2][256];
  logic [15:0] mdl_hex [2];
  logic [15:0] mdl_last [2];
  int          waits [2];

  mem2io_responder_if b0 ();
  mem2io_responder_if b1 ();

  mem2io_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut0 (
    .Clk(clk), .Reset(rst), .Switches(sw), .HEX_out(hex0), .bus(b0)
  );

  mem2io_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut1 (
    .Clk(clk), .Reset(rst), .Switches(sw), .HEX_out(hex1), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic r_of(input int k);
    return (k == 0) ? b0.R : b1.R;
  endfunction

  function automatic logic busy_of(input int k);
    return (k == 0) ? b0.Busy : b1.Busy;
  endfunction

  function automatic logic [15:0] dout_of(input int k);
    return (k == 0) ? b0.Data_to_CPU : b1.Data_to_CPU;
  endfunction

  function automatic logic [15:0] hex_of(input int k);
    return (k == 0) ? hex0 : hex1;
  endfunction

  task automatic drive(input int k, input logic en, input logic we, input logic [15:0] a, input logic [15:0] d);
    if (k == 0) begin
      b0.MEM_EN = en; b0.WE = we; b0.ADDR = a; b0.Data_from_CPU = d;
    end else begin
      b1.MEM_EN = en; b1.WE = we; b1.ADDR = a; b1.Data_from_CPU = d;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic issue(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                       input bit scramble, input bit hold);
    exp_t e;
    bit   seen;
    drive(k, 1'b1, we, a, d);
    if (we) begin
      if (a == 16'hFFFF)   mdl_hex[k] = d;
      else if (a < 16'd256) mdl_mem[k][a[7:0]] = d;
    end else begin
      if (a == 16'hFFFF)    mdl_last[k] = sw;
      else if (a < 16'd256) mdl_last[k] = mdl_mem[k][a[7:0]];
      else                  mdl_last[k] = 16'h0000;
    end
    e.cyc  = cyc + 1 + waits[k];
    e.dout = mdl_last[k];
    e.hex  = mdl_hex[k];
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      chk("busy_during_access", busy_of(k), 1);
      if (r_of(k)) seen = 1;
      else if (scramble)
        drive(k, hold ? 1'b1 : 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    end
    if (!seen) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL r_timeout: inst %0d got no R, want R within 20 cycles", k);
    end
    if (!hold) drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("busy_after_done", busy_of(k), 0);
  endtask

  task automatic random_phase(input int k, input int n);
    logic [15:0] a;
    int          sel;
    for (int i = 0; i < n; i++) begin
      sw  = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 16'hFFFF;
      else if (sel == 1) a = 16'($urandom_range(256, 16'hFFFE));
      else               a = 16'($urandom_range(0, 255));
      issue(k, 1'($urandom), a, 16'($urandom), 1, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && b0.R) begin
      if (q0.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL spurious_r0: got R=1 want no pending request (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("r_cycle0", cyc, e.cyc);
        chk("dout0", b0.Data_to_CPU, e.dout);
        chk("hex0", hex0, e.hex);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && b1.R) begin
      if (q1.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL spurious_r1: got R=1 want no pending request (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("r_cycle1", cyc, e.cyc);
        chk("dout1", b1.Data_to_CPU, e.dout);
        chk("hex1", hex1, e.hex);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    waits[0] = 2;
    waits[1] = 0;
    for (int k = 0; k < 2; k++) begin
      mdl_hex[k]  = 16'h0000;
      mdl_last[k] = 16'h0000;
    end
    rst = 1'b1;
    sw  = 16'h0000;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_r", r_of(k), 0);
      chk("reset_busy", busy_of(k), 0);
      chk("reset_dout", dout_of(k), 0);
      chk("reset_hex", hex_of(k), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 256; a++) issue(0, 1'b1, 16'(a), 16'($urandom), 0, 0);

    // Reset one cycle before a write commit: the write must be dropped and no R issued.
    issue(0, 1'b1, 16'h0020, 16'h1111, 0, 0);
    drive(0, 1'b1, 1'b1, 16'h0020, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("abort_r", b0.R, 0);
    chk("abort_busy", b0.Busy, 0);
    chk("abort_dout", b0.Data_to_CPU, 0);
    chk("abort_hex", hex0, 0);
    @(negedge clk);
    chk("abort_r_late", b0.R, 0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mdl_hex[k]  = 16'h0000;
      mdl_last[k] = 16'h0000;
    end
    issue(0, 1'b0, 16'h0020, 16'h0000, 0, 0);

    issue(0, 1'b1, 16'h0010, 16'h1234, 0, 0);
    issue(0, 1'b0, 16'h0010, 16'h0000, 1, 0);

    issue(0, 1'b1, 16'hFFFF, 16'hBEEF, 0, 0);
    sw = 16'h00A5;
    issue(0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
    sw = 16'h5A5A;
    @(negedge clk);
    chk("io_read_hold", b0.Data_to_CPU, 16'h00A5);
    chk("hex_hold", hex0, 16'hBEEF);

    issue(0, 1'b1, 16'h0100, 16'hFFFF, 0, 0);
    issue(0, 1'b0, 16'h0000, 16'h0000, 0, 0);
    issue(0, 1'b0, 16'h0100, 16'h0000, 0, 0);

    for (int i = 0; i < 8; i++) issue(0, 1'b0, (i % 2 == 0) ? 16'h0001 : 16'h0002, 16'h0000, 1, 1);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    random_phase(0, 150);

    for (int a = 0; a < 256; a++) issue(1, 1'b1, 16'(a), 16'($urandom), 0, 0);
    for (int i = 0; i < 6; i++) issue(1, 1'b0, 16'($urandom_range(0, 255)), 16'h0000, 1, 1);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    random_phase(1, 100);

    repeat (5) @(negedge clk);
    chk("pending0_empty", q0.size(), 0);
    chk("pending1_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2io_responder.md
Name: mem2io_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts read/write requests driven by the control FSM (MEM_EN, WE, MAR, MDR) and services them from an internal word-addressed RAM after a fixed number of wait states.
- Signals completion with a one-cycle ready pulse.
- Returns read data on Data_to_CPU, which feeds the MDR input mux.
- Decodes address 0xFFFF as memory-mapped I/O: a read returns the switches and a write loads the hex display register.

Parameters:
- ADDR_BITS, 8, width of the internal RAM index; RAM holds 2^ADDR_BITS 16-bit words at addresses 0x0000..(2^ADDR_BITS-1).
- WAIT_CYCLES, 2, number of ACCESS-state cycles inserted before completion; legal range is 0..15.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MEM_EN  in  1  request valid; held by the requester until R is seen.
- WE  in  1  1 = write, 0 = read; sampled with MEM_EN.
- ADDR  in  16  word address (from MAR).
- Data_from_CPU  in  16  write data (from MDR).
- Switches  in  16  I/O read source at 0xFFFF.
- R  out  1  ready; a one-cycle pulse marking request completion.
- Data_to_CPU  out  16  read data; valid while R=1 and held afterwards.
- HEX_out  out  16  I/O display register, written at 0xFFFF.
- Busy  out  1  high while in ACCESS or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, R=0, Busy=0, Data_to_CPU=0x0000, HEX_out=0x0000.
  - RAM contents are not cleared and remain unchanged.
  - Reset asserted mid-access aborts the access. Any RAM/HEX write not yet committed is dropped, and no R pulse is issued.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered; R=1 only in DONE.
- IDLE:
  - If MEM_EN=1 at a rising edge, latch ADDR, WE and Data_from_CPU into request registers.
  - Go to ACCESS with counter=WAIT_CYCLES-1, or directly to DONE if WAIT_CYCLES=0.
  - Otherwise remain in IDLE.
- ACCESS:
  - Decrement the counter each edge.
  - When counter=0, the next edge enters DONE.
  - Net effect: ACCESS lasts exactly WAIT_CYCLES cycles.
- Commit edge (the edge entering DONE):
  - Write to RAM: RAM[addr[ADDR_BITS-1:0]] <= latched data.
  - Write to 0xFFFF: HEX_out <= latched data.
  - Read from RAM: Data_to_CPU <= RAM[index].
  - Read from 0xFFFF: Data_to_CPU <= Switches, sampled at this edge.
  - Writes leave Data_to_CPU unchanged.
- DONE:
  - Lasts exactly one cycle with R=1, then returns to IDLE unconditionally.
- Latency: counting the acceptance edge as edge 1, R rises on edge WAIT_CYCLES+1 and falls on edge WAIT_CYCLES+2.
- Back-to-back requests:
  - The requester must drop MEM_EN or present a new request in the cycle after R.
  - MEM_EN=1 in the IDLE cycle after DONE is accepted as a new request.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Request changes after acceptance: ADDR/WE/data changes, or MEM_EN dropping, during ACCESS/DONE are ignored. The latched request completes and R still pulses.
- Out-of-range addresses (ADDR >= 2^ADDR_BITS and != 0xFFFF):
  - Read returns 0x0000.
  - Write is discarded; RAM and HEX_out are unchanged.
  - R pulses normally.
- Address 0xFFFF always decodes as I/O, regardless of ADDR_BITS.
- Data_to_CPU holds its last read value until the next read commit or reset.

Test Plan:
- Reset mid-access, then write 0x1234 to 0x0010 → R rises on edge 3 (WAIT_CYCLES=2), Busy high edges 1–3. Then read 0x0010 → R pulses one cycle with Data_to_CPU=0x1234.
- Write 0xBEEF to 0xFFFF → HEX_out=0xBEEF at the R edge and RAM is unchanged. With Switches=0x00A5, read 0xFFFF → Data_to_CPU=0x00A5; Switches change after commit → Data_to_CPU stays 0x00A5.
- Out of range: write 0xFFFF to 0x0100 (ADDR_BITS=8) → R pulses and RAM[0x00] is unchanged. Read 0x0100 → Data_to_CPU=0x0000.
- MEM_EN held high continuously with WE=0 and ADDR alternating 0x0001/0x0002 → completions every 4 cycles, each returning the correct word. ADDR changed during ACCESS → the originally latched address is used.
- Assert Reset one cycle before a write commit to 0x0020 (old 0x1111, new 0x2222) → no R, RAM[0x20]=0x1111, outputs zero.
- WAIT_CYCLES=0 instance → R on edge 1 after acceptance; a request every 2 cycles succeeds.
